sap_cpu_core: RTL and testbench

Parametrised SAP-class CPU core: the next generation of the team's 8-bit SAP-1, generalised in data and address width and moved from an internal ROM to an external memory port with a ready handshake. Adds RAM stores, immediate loads, unconditional and flag-conditional jumps, a carry/zero flag pair and a halt state. It sits between the Tiny Tapeout top-level wrapper and a program/data memory block; the output register is exposed as a valid-qualified port.

---
 rtl/sap_pkg.sv | 35 +++
 rtl/sap_alu.sv | 24 ++
 rtl/sap_cpu_core.sv | 180 ++++++++++++++++++
 tb/tb_sap_cpu_core.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: opcode encodings, FSM state type and instruction-field widths
// shared by the sap_cpu_core block.
`default_nettype none

package sap_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        MEM    = 2'd2,
        HALT   = 2'd3
    } state_t;

    // Instructions that need a second memory transaction after decode.
    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sap_alu.sv
// sap_alu: combinational DATA_W-bit add/subtract; subtraction is A + ~B + 1,
// so carry_o=1 on subtract means "no borrow".
`default_nettype none

module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   total;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign total = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
    assign {carry_o, sum_o} = total;

endmodule

`default_nettype wire

// File: rtl/sap_cpu_core.sv
// sap_cpu_core: parametrised SAP-class CPU with external ready-handshake memory.
// Define SAP_COND_JUMP_EN to enable JC/JZ and the carry/zero flag registers.
`default_nettype none

module sap_cpu_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              halted_o,
    output logic              flag_c_o,
    output logic              flag_z_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic [OPC_W-1:0]  opc;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] addr;
    logic              rd_req, wr_req;
    logic [DATA_W-1:0] alu_sum;
    logic              alu_c;

`ifdef SAP_COND_JUMP_EN
    logic c_q, c_d, z_q, z_d;
`else
    logic carry_unused;
    assign carry_unused = alu_c;
`endif

    assign opc     = ir_q[DATA_W-1 -: OPC_W];
    assign op_addr = ir_q[ADDR_W-1:0];
    assign imm     = {{OPC_W{1'b0}}, ir_q[DATA_W-OPC_W-1:0]};

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i    (acc_q),
        .b_i    (mem_rdata_i),
        .sub_i  (opc == OP_SUB),
        .sum_o  (alu_sum),
        .carry_o(alu_c)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        addr        = pc_q;
`ifdef SAP_COND_JUMP_EN
        c_d         = c_q;
        z_d         = z_q;
`endif
        case (state_q)
            FETCH: begin
                rd_req = 1'b1;
                if (mem_ready_i) begin
                    ir_d    = mem_rdata_i;
                    pc_d    = pc_q + 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (opc)
                    OP_LDI: begin
                        acc_d = imm;
`ifdef SAP_COND_JUMP_EN
                        z_d   = (imm == '0);
`endif
                    end
                    OP_JMP: pc_d = op_addr;
`ifdef SAP_COND_JUMP_EN
                    OP_JC:  if (c_q) pc_d = op_addr;
                    OP_JZ:  if (z_q) pc_d = op_addr;
`endif
                    OP_OUT: begin
                        out_d       = acc_q;
                        out_valid_d = 1'b1;
                    end
                    default: ;
                endcase
                if (is_mem_op(opc))      state_d = MEM;
                else if (opc == OP_HLT)  state_d = HALT;
                else                     state_d = FETCH;
            end
            MEM: begin
                addr   = op_addr;
                wr_req = (opc == OP_STA);
                rd_req = (opc != OP_STA);
                if (mem_ready_i) begin
                    state_d = FETCH;
                    case (opc)
                        OP_LDA: begin
                            acc_d = mem_rdata_i;
`ifdef SAP_COND_JUMP_EN
                            z_d   = (mem_rdata_i == '0);
`endif
                        end
                        OP_ADD, OP_SUB: begin
                            acc_d = alu_sum;
`ifdef SAP_COND_JUMP_EN
                            c_d   = alu_c;
                            z_d   = (alu_sum == '0);
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SAP_COND_JUMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end
    assign flag_c_o = c_q;
    assign flag_z_o = z_q;
`else
    assign flag_c_o = 1'b0;
    assign flag_z_o = 1'b0;
`endif

    // Gating with rst_n drops an in-flight request as soon as reset asserts.
    assign mem_rd_o    = rd_req & rst_n;
    assign mem_wr_o    = wr_req & rst_n;
    assign mem_addr_o  = addr;
    assign mem_wdata_o = acc_q;
    assign out_data_o  = out_q;
    assign out_valid_o = out_valid_q;
    assign halted_o    = (state_q == HALT);

endmodule

`default_nettype wire

// File: tb/tb_sap_cpu_core.sv
// tb_sap_cpu_core: directed and random programs against an instruction-level model.
`default_nettype none

module tb_sap_cpu_core;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef SAP_COND_JUMP_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_valid, halted, flag_c, flag_z;

    sap_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr_o (mem_addr),
        .mem_rd_o   (mem_rd),
        .mem_wr_o   (mem_wr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .halted_o   (halted),
        .flag_c_o   (flag_c),
        .flag_z_o   (flag_z)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] img [DEPTH];
    logic [DW-1:0] mem [DEPTH];
    assign mem_rdata = mem[mem_addr];

    int checks = 0, failures = 0;
    int viol = 0, wr_cyc = 0, wr_acc = 0, wcnt = 0, cur_wait = 0, wait_fixed = 0;
    bit rand_mode = 1'b0;
    bit pend = 1'b0;
    logic          p_rd, p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] dut_outq[$];

    int            m_acc, m_pc, m_c, m_z, m_cyc;
    int            m_outq[$];
    logic [DW-1:0] m_mem [DEPTH];

    // Memory image is reloaded while reset is held; stores land on accepted edges.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = img[i];
            wr_acc = 0;
        end else if (mem_wr && mem_ready) begin
            mem[mem_addr] = mem_wdata;
            wr_acc++;
        end
    end

    // Protocol monitor and wait-state generator.
    always @(negedge clk) begin
        if (!rst_n) begin
            viol = 0; wr_cyc = 0; dut_outq.delete();
            pend = 1'b0; wcnt = 0; mem_ready = 1'b1;
        end else begin
            bit req, new_req;
            req = mem_rd || mem_wr;
            if (pend && !mem_ready &&
                (mem_rd !== p_rd || mem_wr !== p_wr || mem_addr !== p_addr || mem_wdata !== p_wdata))
                viol++;
            if (mem_rd && mem_wr) viol++;
            if (halted && req) viol++;
            if (out_valid) dut_outq.push_back(out_data);
            if (mem_wr) wr_cyc++;
            new_req = req && (!pend || mem_ready);
            if (new_req) begin
                wcnt = 0;
                cur_wait = rand_mode ? int'($urandom_range(0, 2)) : wait_fixed;
            end
            pend = req; p_rd = mem_rd; p_wr = mem_wr; p_addr = mem_addr; p_wdata = mem_wdata;
            if (req) begin
                if (wcnt < cur_wait) begin mem_ready = 1'b0; wcnt++; end
                else mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Instruction-level reference: executes img until HLT, tallying zero-wait cycles.
    task automatic model_run(input int limit, output bit ok);
        int pc, acc, c, z, n, op, a, s;
        logic [DW-1:0] w;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = img[i];
        m_outq.delete();
        pc = 0; acc = 0; c = 0; z = 0; n = 0; ok = 1'b0; m_cyc = 0;
        while (!ok && n < limit) begin
            w  = m_mem[pc];
            pc = (pc + 1) % DEPTH;
            op = int'(w[DW-1:DW-4]);
            a  = int'(w[AW-1:0]);
            m_cyc += (op >= 1 && op <= 4) ? 3 : 2;
            case (op)
                1: begin acc = int'(m_mem[a]); if (COND) z = (acc == 0); end
                2: begin
                    s = acc + int'(m_mem[a]);
                    if (COND) c = (s >= 256);
                    acc = s % 256;
                    if (COND) z = (acc == 0);
                end
                3: begin
                    if (COND) c = (acc >= int'(m_mem[a]));
                    acc = (acc - int'(m_mem[a]) + 256) % 256;
                    if (COND) z = (acc == 0);
                end
                4: m_mem[a] = DW'(acc);
                5: begin acc = int'(w[DW-5:0]); if (COND) z = (acc == 0); end
                6: pc = a;
                7: if (COND && c != 0) pc = a;
                8: if (COND && z != 0) pc = a;
                14: m_outq.push_back(acc);
                15: ok = 1'b1;
                default: ;
            endcase
            n++;
        end
        m_acc = acc; m_pc = pc; m_c = c; m_z = z;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int bound, output int cyc, output bit done);
        do_reset();
        cyc = 0; done = 1'b0;
        while (!done && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
            if (halted === 1'b1) done = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_img();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h00;
    endtask

    task automatic test_reset();
        clear_img();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_rd, mem_wr, out_valid, halted, flag_c, flag_z} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got rd/wr/ov/h/c/z=%b required 000000",
                     {mem_rd, mem_wr, out_valid, halted, flag_c, flag_z});
        end
        checks++;
        if (out_data !== 8'h00) begin
            failures++; $display("FAIL reset_out_data: got %0h required 0", out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
            failures++; $display("FAIL first_fetch: got rd=%b addr=%0h required rd=1 addr=0", mem_rd, mem_addr);
        end
    endtask

    task automatic test_add_program();
        int cyc; bit done, ok;
        clear_img();
        img[0] = 8'h19; img[1] = 8'h2A; img[2] = 8'hE0; img[3] = 8'hF0;
        img[9] = 8'h1C; img[10] = 8'h0E;
        rand_mode = 1'b0; wait_fixed = 0;
        model_run(50, ok);
        run_to_halt(200, cyc, done);
        checks++;
        if (!done || cyc != 10) begin
            failures++; $display("FAIL add_halt_cycles: got done=%0d cycles=%0d required 1/10", done, cyc);
        end
        checks++;
        if (dut_outq.size() != 1) begin
            failures++; $display("FAIL add_out_pulses: got %0d required 1", dut_outq.size());
        end else if (dut_outq[0] !== 8'h2A) begin
            failures++; $display("FAIL add_out_data: got %0h required 2a", dut_outq[0]);
        end
        checks++;
        if (m_cyc != cyc) begin
            failures++; $display("FAIL add_model_cycles: got %0d required %0d", cyc, m_cyc);
        end
    endtask

    task automatic test_sub();
        logic [7:0] a_imm [2] = '{8'h55, 8'h57};
        int exp_acc [2] = '{254, 0};
        int cyc; bit done, ok;
        for (int k = 0; k < 2; k++) begin
            clear_img();
            img[0] = a_imm[k]; img[1] = 8'h39; img[2] = 8'hF0; img[9] = 8'h07;
            model_run(50, ok);
            run_to_halt(200, cyc, done);
            checks++;
            if (!done || int'(dut.acc_q) != exp_acc[k]) begin
                failures++; $display("FAIL sub%0d_acc: got %0h required %0h", k, dut.acc_q, exp_acc[k]);
            end
            checks++;
            if (int'(flag_c) != m_c || int'(flag_z) != m_z) begin
                failures++; $display("FAIL sub%0d_flags: got c=%b z=%b required c=%0d z=%0d", k, flag_c, flag_z, m_c, m_z);
            end
        end
    endtask

`ifdef SAP_COND_JUMP_EN
    task automatic test_loop();
        int cyc; bit done, ok;
        clear_img();
        img[0] = 8'h53; img[1] = 8'h3E; img[2] = 8'h8F; img[3] = 8'h61;
        img[14] = 8'h01; img[15] = 8'hF0;
        model_run(100, ok);
        run_to_halt(500, cyc, done);
        checks++;
        if (!done || dut.acc_q !== 8'h00 || dut.pc_q !== 4'h0) begin
            failures++; $display("FAIL loop_final: got done=%0d acc=%0h pc=%0h required 1/0/0", done, dut.acc_q, dut.pc_q);
        end
        checks++;
        if (cyc != m_cyc) begin
            failures++; $display("FAIL loop_cycles: got %0d required %0d", cyc, m_cyc);
        end
    endtask
`endif

    task automatic test_cond_jump();
        int cyc; bit done, ok;
        clear_img();
        img[0] = 8'h50; img[1] = 8'h84; img[2] = 8'h51; img[3] = 8'hE0; img[4] = 8'hF0;
        model_run(50, ok);
        run_to_halt(200, cyc, done);
        checks++;
        if (!done || int'(dut.acc_q) != m_acc || int'(flag_z) != m_z) begin
            failures++; $display("FAIL jz_effect: got acc=%0h z=%b required acc=%0h z=%0d", dut.acc_q, flag_z, m_acc, m_z);
        end
        checks++;
        if (dut_outq.size() != m_outq.size() || cyc != m_cyc) begin
            failures++; $display("FAIL jz_path: got outs=%0d cycles=%0d required outs=%0d cycles=%0d",
                                 dut_outq.size(), cyc, m_outq.size(), m_cyc);
        end
    endtask

    task automatic test_sta_wait();
        int cyc; bit done;
        clear_img();
        img[0] = 8'h1D; img[1] = 8'h4E; img[2] = 8'hF0; img[13] = 8'h5A;
        wait_fixed = 3;
        run_to_halt(300, cyc, done);
        wait_fixed = 0;
        checks++;
        if (!done || mem[14] !== 8'h5A) begin
            failures++; $display("FAIL sta_data: got done=%0d mem[e]=%0h required 1/5a", done, mem[14]);
        end
        checks++;
        if (wr_acc != 1 || wr_cyc != 4) begin
            failures++; $display("FAIL sta_handshake: got accepts=%0d wr_cycles=%0d required 1/4", wr_acc, wr_cyc);
        end
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL sta_stability: got %0d violations required 0", viol);
        end
    endtask

    task automatic test_reset_mid();
        clear_img();
        img[0] = 8'h57; img[1] = 8'hE0; img[2] = 8'h19; img[3] = 8'hF0; img[9] = 8'h33;
        do_reset();
        repeat (4) @(posedge clk);
        #1 wait_fixed = 10;
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (mem_rd !== 1'b1 || out_data !== 8'h07) begin
            failures++; $display("FAIL pre_reset_state: got rd=%b out=%0h required 1/07", mem_rd, out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr, out_valid, halted} !== 4'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL async_reset: got rd/wr/ov/h=%b out=%0h required 0000/00",
                                 {mem_rd, mem_wr, out_valid, halted}, out_data);
        end
        wait_fixed = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
            failures++; $display("FAIL refetch: got rd=%b addr=%0h required 1/0", mem_rd, mem_addr);
        end
    endtask

    task automatic test_random();
        int cyc, tries; bit done, ok;
        rand_mode = 1'b1;
        for (int p = 0; p < 25; p++) begin
            tries = 0;
            do begin
                for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
                model_run(60, ok);
                tries++;
            end while (!ok && tries < 200);
            if (!ok) begin
                img[0] = 8'hF0;
                model_run(60, ok);
            end
            run_to_halt(2000, cyc, done);
            checks++;
            if (!done) begin
                failures++; $display("FAIL rand%0d_halt: no halt within %0d cycles", p, cyc);
            end
            checks++;
            if (int'(dut.acc_q) != m_acc || int'(dut.pc_q) != m_pc) begin
                failures++; $display("FAIL rand%0d_regs: got acc=%0h pc=%0h required acc=%0h pc=%0h",
                                     p, dut.acc_q, dut.pc_q, m_acc, m_pc);
            end
            checks++;
            if (int'(flag_c) != m_c || int'(flag_z) != m_z) begin
                failures++; $display("FAIL rand%0d_flags: got c=%b z=%b required c=%0d z=%0d", p, flag_c, flag_z, m_c, m_z);
            end
            checks++;
            if (dut_outq.size() != m_outq.size()) begin
                failures++; $display("FAIL rand%0d_out_count: got %0d required %0d", p, dut_outq.size(), m_outq.size());
            end else begin
                for (int i = 0; i < m_outq.size(); i++) begin
                    checks++;
                    if (int'(dut_outq[i]) != m_outq[i]) begin
                        failures++; $display("FAIL rand%0d_out%0d: got %0h required %0h", p, i, dut_outq[i], m_outq[i]);
                    end
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (mem[i] !== m_mem[i]) begin
                    failures++; $display("FAIL rand%0d_mem%0d: got %0h required %0h", p, i, mem[i], m_mem[i]);
                end
            end
            checks++;
            if (viol != 0) begin
                failures++; $display("FAIL rand%0d_protocol: got %0d violations required 0", p, viol);
            end
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_program();
        test_sub();
`ifdef SAP_COND_JUMP_EN
        test_loop();
`endif
        test_cond_jump();
        test_sta_wait();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
